// File: rtl/fanout_pkg.sv
// fanout_pkg: shared constants and types for the fanout fork controllers
package fanout_pkg;
  localparam int DATA_W_DEFAULT = 17;
  localparam int MAX_FANOUT = 16;
  typedef logic [MAX_FANOUT-1:0] fanout_mask_t;
  typedef enum logic {IDLE, PARTIAL} fork_state_e;
endpackage

// File: rtl/fanout_ready_reduce.sv
// fanout_ready_reduce: a branch is done when deselected, already taken, or ready now; upstream may proceed when all are done
module fanout_ready_reduce
  import fanout_pkg::*;
#(
  parameter int N = MAX_FANOUT
) (
  input  logic [N-1:0] mask,
  input  logic [N-1:0] taken,
  input  logic [N-1:0] ready,
  output logic         all_done
);
  assign all_done = &(~mask | taken | ready);
endmodule

// File: rtl/fanout_fork_ctrl.sv
// fanout_fork_ctrl: eager fork broadcasting one token stream to masked branches; optional stats via FANOUT_FORK_STATS_EN
module fanout_fork_ctrl
  import fanout_pkg::*;
#(
  parameter int NUM_OUT = 6,
  parameter int DATA_W  = DATA_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic                      flush,
  input  logic                      cfg_en,
  input  logic [NUM_OUT-1:0]        cfg_mask,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic [NUM_OUT-1:0]        out_valid,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic                      busy,
`ifdef FANOUT_FORK_STATS_EN
  output logic [15:0]               tok_count,
  output logic [15:0]               stall_count,
`endif
  output logic                      cfg_err
);
  logic [NUM_OUT-1:0] mask, mask_d, taken, taken_d, accept;
  fork_state_e state, state_d;
  logic all_done, fire, live;

  fanout_ready_reduce #(.N(NUM_OUT)) u_reduce (
    .mask     (mask),
    .taken    (taken),
    .ready    (out_ready),
    .all_done (all_done)
  );

  assign live      = clk_en & ~flush;
  assign in_ready  = live & all_done;
  assign out_valid = {NUM_OUT{live & in_valid}} & mask & ~taken;
  assign out_data  = {NUM_OUT{in_data}};
  assign accept    = out_valid & out_ready;
  assign fire      = in_valid & in_ready;
  assign busy      = state == PARTIAL;
  assign cfg_err   = live & cfg_en & busy;

  // next taken set, mask load and IDLE/PARTIAL tracking; flush wins over the handshake and unlocks cfg
  always_comb begin
    taken_d = !clk_en ? taken : (flush || fire) ? '0 : taken | accept;
    mask_d  = (clk_en && cfg_en && (!busy || flush)) ? cfg_mask : mask;
    state_d = (taken_d != '0) ? PARTIAL : IDLE;
  end

  // state registers, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      taken <= '0;
      mask  <= '0;
    end else begin
      state <= state_d;
      taken <= taken_d;
      mask  <= mask_d;
    end
  end

`ifdef FANOUT_FORK_STATS_EN
  // saturating completed-broadcast and stall counters, cleared by flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tok_count   <= '0;
      stall_count <= '0;
    end else if (clk_en) begin
      tok_count   <= flush ? '0 : (fire && ~&tok_count) ? tok_count + 16'd1 : tok_count;
      stall_count <= flush ? '0 : (in_valid && !in_ready && ~&stall_count) ? stall_count + 16'd1 : stall_count;
    end
  end
`endif

  a_hold_valid: assert property (@(posedge clk) disable iff (reset) (clk_en && busy && !flush) |-> in_valid);
endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// tb_fanout_fork_ctrl: directed vectors with a per-cycle expectation queue checked by an independent monitor
module tb_fanout_fork_ctrl;
  logic clk = 1'b0, reset = 1'b1, clk_en = 1'b1, flush = 1'b0, cfg_en = 1'b0, in_valid = 1'b0;
  logic [5:0] cfg_mask = '0, out_ready = '0, out_valid;
  logic [16:0] in_data = '0;
  logic [101:0] out_data;
  logic in_ready, busy, cfg_err;
`ifdef FANOUT_FORK_STATS_EN
  logic [15:0] tok_count, stall_count;
`endif

  typedef struct {
    logic ir;
    logic [5:0] ov;
    logic busy;
    logic err;
    logic [16:0] d;
    logic st;
    logic [15:0] tok;
    logic [15:0] stall;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  fanout_fork_ctrl dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .cfg_en(cfg_en),
    .cfg_mask(cfg_mask), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy),
`ifdef FANOUT_FORK_STATS_EN
    .tok_count(tok_count), .stall_count(stall_count),
`endif
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic cyc(input logic rs, input logic ce, input logic fl, input logic cen, input logic [5:0] cm,
                     input logic iv, input logic [16:0] d, input logic [5:0] ordy,
                     input logic e_ir, input logic [5:0] e_ov, input logic e_busy, input logic e_err,
                     input logic st, input logic [15:0] e_tok, input logic [15:0] e_stall);
    exp_t e;
    @(negedge clk);
    reset = rs; clk_en = ce; flush = fl; cfg_en = cen; cfg_mask = cm;
    in_valid = iv; in_data = d; out_ready = ordy;
    e.ir = e_ir; e.ov = e_ov; e.busy = e_busy; e.err = e_err; e.d = d;
    e.st = st; e.tok = e_tok; e.stall = e_stall;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("in_ready", 32'(in_ready), 32'(e.ir));
        chk("out_valid", 32'(out_valid), 32'(e.ov));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("cfg_err", 32'(cfg_err), 32'(e.err));
        for (int i = 0; i < 6; i++) chk($sformatf("out_data[%0d]", i), 32'(out_data[i*17 +: 17]), 32'(e.d));
`ifdef FANOUT_FORK_STATS_EN
        if (e.st) begin
          chk("tok_count", 32'(tok_count), 32'(e.tok));
          chk("stall_count", 32'(stall_count), 32'(e.stall));
        end
`endif
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    //   rs ce fl cen cfg_mask  iv data      ready       ir ov          busy err st tok stall
    cyc(0, 1, 0, 0, 6'b000000, 0, 17'h0000, 6'b000000, 1, 6'b000000, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 1, 6'b000111, 0, 17'h0000, 6'b000000, 1, 6'b000000, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b000000, 1, 17'h00A5, 6'b111111, 1, 6'b000111, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b000000, 0, 17'h0000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b000000, 1, 17'h0123, 6'b000001, 0, 6'b000111, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b000000, 1, 17'h0123, 6'b000010, 0, 6'b000110, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b000000, 1, 17'h0123, 6'b000100, 1, 6'b000100, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b000000, 0, 17'h0000, 6'b000000, 0, 6'b000000, 0, 0, 1, 2, 2);
    cyc(0, 1, 1, 1, 6'b000000, 0, 17'h0000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b000000, 1, 17'h1001, 6'b000000, 1, 6'b000000, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 6'b000000, 1, 17'h1002, 6'b000000, 1, 6'b000000, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b000000, 1, 17'h1003, 6'b000000, 1, 6'b000000, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b000000, 1, 17'h1FFFF, 6'b000000, 1, 6'b000000, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 6'b000111, 0, 17'h0000, 6'b000000, 1, 6'b000000, 0, 0, 1, 4, 0);
    cyc(0, 1, 0, 0, 6'b000000, 1, 17'h1111, 6'b000001, 0, 6'b000111, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 6'b110000, 1, 17'h1111, 6'b000000, 0, 6'b000110, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 6'b110000, 1, 17'h1111, 6'b000110, 1, 6'b000110, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 6'b110000, 0, 17'h0000, 6'b000000, 0, 6'b000000, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b000000, 1, 17'h0ABC, 6'b010000, 0, 6'b110000, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 6'b000000, 1, 17'h0ABC, 6'b100000, 0, 6'b000000, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b000000, 1, 17'h0ABC, 6'b000000, 0, 6'b110000, 0, 0, 1, 0, 1);
    cyc(0, 1, 0, 0, 6'b000000, 1, 17'h0ABC, 6'b110000, 1, 6'b110000, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 6'b000001, 1, 17'h0555, 6'b111111, 0, 6'b000000, 0, 0, 1, 1, 1);
    cyc(0, 1, 0, 0, 6'b000000, 1, 17'h0555, 6'b100000, 0, 6'b110000, 0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 6'b000000, 1, 17'h0555, 6'b010000, 0, 6'b000000, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b000000, 1, 17'h0555, 6'b010000, 1, 6'b010000, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b000000, 1, 17'h0777, 6'b100000, 0, 6'b110000, 0, 0, 1, 2, 1);
    cyc(1, 1, 0, 0, 6'b000000, 1, 17'h0777, 6'b000000, 1, 6'b000000, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 6'b000000, 0, 17'h0000, 6'b000000, 1, 6'b000000, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 6'b000000, 1, 17'h0999, 6'b000000, 1, 6'b000000, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fanout_fork_ctrl.md
Name: fanout_fork_ctrl

Overview:
- Eager-fork controller that broadcasts one valid/ready token stream to up to NUM_OUT consumers in the sparse streaming fabric.
- Per-branch "taken" state lets each selected consumer accept independently. Upstream sees in_ready only once every enabled, selected branch has accepted or accepts in the current cycle.
- Owns the fanout select mask: a config load, held in a register.
- Sits between a primitive's output port and the routing fanout that feeds downstream scanners, intersecters and writers.

Parameters:
- NUM_OUT, 6, number of fanout branches (1..16).
- DATA_W, 17, token width: 16-bit payload plus 1 stop/control bit.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- clk_en  in  1  global clock enable; low freezes all state.
- flush  in  1  synchronous flush; clears in-flight partial state.
- cfg_en  in  1  load cfg_mask into the select register this cycle.
- cfg_mask  in  NUM_OUT  per-branch enable/select bits.
- in_valid  in  1  upstream token valid.
- in_data  in  DATA_W  upstream token.
- in_ready  out  1  upstream handshake ready.
- out_valid  out  NUM_OUT  per-branch valid.
- out_data  out  NUM_OUT*DATA_W  per-branch data; every slice equals in_data.
- out_ready  in  NUM_OUT  per-branch ready.
- busy  out  1  high when any taken bit is set (partial broadcast in progress).
- cfg_err  out  1  one-cycle pulse: cfg_en rejected because busy.

Behaviour:
- Reset values: mask=0, taken=0, cfg_err=0.
  - Combinational outputs after reset: in_ready=1 (empty mask), out_valid=0, busy=0.
- Latency: zero cycles. Data and valid pass through combinationally; only partial acceptance is stored.
- Definitions:
  - out_valid[i] = clk_en & in_valid & mask[i] & ~taken[i].
  - done[i] = ~mask[i] | taken[i] | out_ready[i].
  - in_ready = clk_en & AND(done[*]).
- Branch acceptance: if out_valid[i] & out_ready[i], branch i has taken the token.
  - If in_valid & in_ready in the same cycle, the broadcast completes: all taken bits clear next cycle.
  - Otherwise taken[i] sets next cycle.
- States:
  - IDLE: taken==0.
  - PARTIAL: taken!=0.
  - IDLE->PARTIAL: at least one branch accepts but the broadcast does not complete.
  - PARTIAL->IDLE: broadcast completes, or flush.
- Mask all zero: in_ready=1 and tokens are consumed and dropped (sink mode); out_valid stays 0.
- Protocol:
  - Upstream holds in_valid and in_data stable while in_valid & ~in_ready.
  - Taken bits are retained if in_valid drops in PARTIAL (protocol violation; flagged by assertion, not corrected).
- Config:
  - cfg_en in IDLE: mask<=cfg_mask next cycle. The new mask governs from the following cycle.
  - cfg_en while busy: ignored; cfg_err pulses for one cycle.
  - cfg_en in the same cycle as completion (busy=1): still rejected.
- flush:
  - Clears taken and forces in_ready=0 and out_valid=0 that cycle. Mask unchanged.
  - Priority: reset > flush > cfg/handshake.
  - cfg_en together with flush: load accepted.
- clk_en=0: no state updates, in_ready=0, out_valid=0, cfg_err=0.
- reset asserted mid-PARTIAL: taken and mask clear immediately (asynchronous); outputs drop in the same cycle.
- NUM_OUT=1: degenerates to a wire with a mask gate; taken never sets.

Optional Feature:
- Macro: FANOUT_FORK_STATS_EN.
- With the macro:
  - Adds output tok_count [15:0]: saturating count of completed broadcasts (in_valid & in_ready), dropped sink-mode tokens included.
  - Adds output stall_count [15:0]: saturating count of cycles with in_valid & ~in_ready & clk_en.
  - Both counters clear on reset and flush, and hold at 16'hFFFF.
- Without the macro: neither port nor register exists; behaviour is otherwise identical.

Decomposition:
- Shared package fanout_pkg:
  - Constant DATA_W_DEFAULT=17.
  - Constant MAX_FANOUT=16.
  - typedef fanout_mask_t (logic [MAX_FANOUT-1:0]).
  - enum fork_state_e {IDLE, PARTIAL}.
- One natural sub-module, fanout_ready_reduce: the combinational done[]/AND reduction over mask, taken and out_ready. It is reused by other multi-consumer ports.

Test Plan:
- Mask 6'b000111, all out_ready=1, in_data=17'h00A5 -> in_ready=1 same cycle; out_valid=6'b000111; all three slices 17'h00A5; busy stays 0.
- Mask 6'b000111; out_ready=6'b000001 at cycle 0, 6'b000010 at cycle 1, 6'b000100 at cycle 2 -> taken goes 001, then 011. in_ready=1 only at cycle 2, then IDLE. Each branch sees exactly one valid beat.
- Mask 0, in_valid=1 for 4 tokens -> in_ready=1 every cycle; out_valid=0; tok_count=4 with FANOUT_FORK_STATS_EN.
- In PARTIAL (taken=6'b000001), pulse cfg_en with cfg_mask=6'b110000 -> cfg_err=1 for one cycle; mask still 6'b000111. After completion, a retry loads 6'b110000.
- In PARTIAL, assert flush -> taken=0 next cycle, out_valid=0 and in_ready=0 in the flush cycle. Next broadcast re-presents to all masked branches.
- Assert reset asynchronously mid-PARTIAL -> busy, out_valid and mask go to 0 without a clock edge. In that state in_ready=1, since the empty mask means sink mode.
